sdram_frame_wr_arbiter: RTL and testbench

- Shares the single SDRAM controller write port (sys_load/sys_data/sys_we/sys_addr) between two frame-writing requesters, e.g. the LCD test-pattern generator and a second image source.
- Grants ownership per frame, round-robin on contention.
- Issues the frame-start sys_load pulse and generates linear write addresses.
- Sits between the pattern/data sources and the SDRAM controller's sys-side interface.

---
 rtl/sdram_frame_wr_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sdram_frame_wr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_wr_arbiter.sv
// sdram_frame_wr_arbiter
// Shares the SDRAM controller sys-side write port between two frame-writing
// requesters. Ownership is granted per frame and alternates round-robin when
// both requesters want the port. The owning requester gets a frame-start
// sys_load pulse, and its pixels are written to linear addresses starting at
// BASE_ADDR.
// Optional build macro: WR_TIMEOUT_EN adds an idle-write watchdog. It ends a
// frame with abort after TIMEOUT_CYCLES consecutive ACTIVE cycles without an
// accepted write.
module sdram_frame_wr_arbiter #(
  parameter int unsigned H_DISP         = 640,
  parameter int unsigned V_DISP         = 480,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys_vaild,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [23:0] data0,
  input  logic [23:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        abort,
  output logic        sys_load,
  output logic        sys_we,
  output logic [23:0] sys_data,
  output logic [31:0] sys_addr
);

  localparam int unsigned FRAME_PIXELS = H_DISP * V_DISP;
  localparam logic [23:0] LAST_PIX     = 24'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_grant_q, last_grant_d;
  logic        abort_q, abort_d;
  logic [23:0] pix_cnt_q, pix_cnt_d;
  logic        sys_we_q, sys_we_d;
  logic [23:0] sys_data_q, sys_data_d;
  logic [31:0] sys_addr_q, sys_addr_d;

  logic        owner_active;
  logic        sel_we;
  logic        sel_req;
  logic [23:0] sel_data;
  logic        accept;
  logic        timeout_hit;

  // Route the selected requester's signals; the other requester's strobes are ignored
  always_comb begin
    sel_we   = sel_q ? we1   : we0;
    sel_req  = sel_q ? req1  : req0;
    sel_data = sel_q ? data1 : data0;
    accept   = (state_q == ACTIVE) && sel_we && sys_vaild;
  end

`ifdef WR_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  // Count consecutive ACTIVE cycles without an accepted write; the last allowed one trips the watchdog
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    timeout_hit = 1'b0;
    if (state_q == LOAD) begin
      idle_cnt_d = '0;
    end else if (state_q == ACTIVE) begin
      if (accept) begin
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d  = idle_cnt_q + 1'b1;
        timeout_hit = (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1));
      end
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic: arbitration in IDLE, counter clear in LOAD, write capture and frame end in ACTIVE
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    abort_d      = abort_q;
    pix_cnt_d    = pix_cnt_q;
    sys_we_d     = 1'b0;
    sys_data_d   = sys_data_q;
    sys_addr_d   = sys_addr_q;

    case (state_q)
      IDLE: begin
        if (sys_vaild && (req0 || req1)) begin
          if (req0 && req1) begin
            sel_d = ~last_grant_q;
          end else begin
            sel_d = req1;
          end
          abort_d = 1'b0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        pix_cnt_d = '0;
        state_d   = ACTIVE;
      end

      ACTIVE: begin
        if (accept) begin
          sys_we_d   = 1'b1;
          sys_data_d = sel_data;
          sys_addr_d = BASE_ADDR + {8'h00, pix_cnt_q};
          pix_cnt_d  = pix_cnt_q + 24'd1;
        end
        if (accept && (pix_cnt_q == LAST_PIX)) begin
          abort_d = 1'b0;
          state_d = DONE;
        end else if (!sel_req || timeout_hit) begin
          abort_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        last_grant_d = sel_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      abort_q      <= 1'b0;
      pix_cnt_q    <= '0;
      sys_we_q     <= 1'b0;
      sys_data_q   <= '0;
      sys_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      abort_q      <= abort_d;
      pix_cnt_q    <= pix_cnt_d;
      sys_we_q     <= sys_we_d;
      sys_data_q   <= sys_data_d;
      sys_addr_q   <= sys_addr_d;
    end
  end

  // Decode grants and pulses straight from registered state so they are glitch-free
  always_comb begin
    owner_active = (state_q == LOAD) || (state_q == ACTIVE);
    gnt0         = owner_active && !sel_q;
    gnt1         = owner_active &&  sel_q;
    sys_load     = (state_q == LOAD);
    done0        = (state_q == DONE) && !sel_q;
    done1        = (state_q == DONE) &&  sel_q;
    abort        = (state_q == DONE) && abort_q;
    sys_we       = sys_we_q;
    sys_data     = sys_data_q;
    sys_addr     = sys_addr_q;
  end

endmodule

// File: tb/tb_sdram_frame_wr_arbiter.sv
// tb_sdram_frame_wr_arbiter
// Directed scenarios followed by randomized traffic. Results are checked
// every cycle against a frame-level behavioural model. The model follows the
// WR_TIMEOUT_EN macro in the same way as the design.
module tb_sdram_frame_wr_arbiter;

  localparam int          H     = 4;
  localparam int          V     = 2;
  localparam int          FRAME = H * V;
  localparam logic [31:0] BASE  = 32'h100;
  localparam int          TO    = 16;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_ACTIVE = 2;
  localparam int P_DONE   = 3;

  logic        clk;
  logic        rst_n;
  logic        sys_vaild;
  logic        req0, req1, we0, we1;
  logic [23:0] data0, data1;
  logic        gnt0, gnt1, done0, done1, abort, sys_load, sys_we;
  logic [23:0] sys_data;
  logic [31:0] sys_addr;

  sdram_frame_wr_arbiter #(
    .H_DISP(H), .V_DISP(V), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sys_vaild(sys_vaild),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .abort(abort), .sys_load(sys_load), .sys_we(sys_we),
    .sys_data(sys_data), .sys_addr(sys_addr)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVectors = 0;
  int nMiss    = 0;

  // Model of the frame arbiter. The model keeps per-frame bookkeeping: the phase, the owner, the writes so far and the idle run.
  int          mPhase;
  bit          mOwner, mLast, mAbort;
  int          mCount, mIdleRun, mFrames;
  bit          mWe;
  logic [23:0] mData;
  logic [31:0] mAddr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    if (observed !== expected) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = P_IDLE; mOwner = 1'b0; mLast = 1'b1; mAbort = 1'b0;
    mCount = 0; mIdleRun = 0; mWe = 1'b0; mData = '0; mAddr = '0;
  endtask

  task automatic modelStep();
    bit accepted;
    mWe = 1'b0;
    case (mPhase)
      P_IDLE: begin
        if (sys_vaild && (req0 || req1)) begin
          mOwner = (req0 && req1) ? ~mLast : req1;
          mPhase = P_LOAD;
        end
      end
      P_LOAD: begin
        mCount = 0; mIdleRun = 0; mPhase = P_ACTIVE;
      end
      P_ACTIVE: begin
        accepted = (mOwner ? we1 : we0) && sys_vaild;
        if (accepted) begin
          mWe = 1'b1;
          mData = mOwner ? data1 : data0;
          mAddr = BASE + 32'(mCount);
          mCount++;
          mIdleRun = 0;
        end else begin
          mIdleRun++;
        end
        if (accepted && mCount == FRAME) begin
          mPhase = P_DONE; mAbort = 1'b0;
        end else if (!(mOwner ? req1 : req0)) begin
          mPhase = P_DONE; mAbort = 1'b1;
        end
`ifdef WR_TIMEOUT_EN
        else if (mIdleRun >= TO) begin
          mPhase = P_DONE; mAbort = 1'b1;
        end
`endif
      end
      default: begin
        mLast = mOwner; mPhase = P_IDLE; mFrames++;
      end
    endcase
  endtask

  task automatic compareAll();
    bit owning;
    owning = (mPhase == P_LOAD) || (mPhase == P_ACTIVE);
    checkOutput("gnt0", 32'(gnt0), 32'(owning && !mOwner));
    checkOutput("gnt1", 32'(gnt1), 32'(owning && mOwner));
    checkOutput("gntExcl", 32'(gnt0 & gnt1), 32'd0);
    checkOutput("sysLoad", 32'(sys_load), 32'(mPhase == P_LOAD));
    checkOutput("done0", 32'(done0), 32'(mPhase == P_DONE && !mOwner));
    checkOutput("done1", 32'(done1), 32'(mPhase == P_DONE && mOwner));
    checkOutput("abort", 32'(abort), 32'(mPhase == P_DONE && mAbort));
    checkOutput("sysWe", 32'(sys_we), 32'(mWe));
    checkOutput("sysData", 32'(sys_data), 32'(mData));
    checkOutput("sysAddr", sys_addr, mAddr);
  endtask

  // Inputs are driven at the falling edge; outputs are checked at the next falling edge
  task automatic applyStimulus(input bit r0, input bit r1, input bit w0, input bit w1,
                               input bit v, input logic [23:0] d0, input logic [23:0] d1);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1; sys_vaild = v; data0 = d0; data1 = d1;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    bit reached;
    bit rr0, rr1;
    rst_n = 1'b0; sys_vaild = 1'b0; req0 = 1'b0; req1 = 1'b0;
    we0 = 1'b0; we1 = 1'b0; data0 = '0; data1 = '0;
    mFrames = 0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    compareAll();
    rst_n = 1'b1;

    // First frame from requester 0 with constant red pixels
    for (int i = 0; i < 14; i++) applyStimulus(1, 0, 1, 0, 1, 24'hFF0000, 24'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 24'h0, 24'h0);

    // Both requesting continuously: grants must alternate
    for (int i = 0; i < 50; i++) applyStimulus(1, 1, 1, 1, 1, 24'($urandom), 24'($urandom));

    // Drop req1 after three accepted writes in its frame
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (mPhase == P_ACTIVE && mOwner && mCount == 3) reached = 1'b1;
      else applyStimulus(1, 1, 1, 1, 1, 24'($urandom), 24'($urandom));
    end
    checkOutput("reachAbortPoint", 32'(reached), 32'd1);
    applyStimulus(1, 0, 1, 0, 1, 24'h0A0A0A, 24'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 1, 1, 24'($urandom), 24'($urandom));
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 1, 24'h0, 24'h0);

    // sys_vaild gap mid-frame while we0 stays high
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (mPhase == P_ACTIVE && !mOwner && mCount == 3) reached = 1'b1;
      else applyStimulus(1, 0, 1, 0, 1, 24'($urandom), 24'h0);
    end
    checkOutput("reachGapPoint", 32'(reached), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 0, 0, 24'($urandom), 24'h0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, 0, 1, 24'($urandom), 24'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 24'h0, 24'h0);

    // Granted source stops writing for a long time
    for (int i = 0; i < 110; i++) applyStimulus(1, 0, 0, 0, 1, 24'h0, 24'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 24'h0, 24'h0);

    // Asynchronous reset in the middle of a frame
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (mPhase == P_ACTIVE && mCount == 2) reached = 1'b1;
      else applyStimulus(1, 0, 1, 0, 1, 24'($urandom), 24'h0);
    end
    checkOutput("reachResetPoint", 32'(reached), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstGnt0", 32'(gnt0), 32'd0);
    checkOutput("rstSysWe", 32'(sys_we), 32'd0);
    checkOutput("rstSysLoad", 32'(sys_load), 32'd0);
    modelReset();
    @(negedge clk);
    compareAll();
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) applyStimulus(1, 0, 1, 0, 1, 24'($urandom), 24'h0);

    // Randomized traffic with requests that stay high for long stretches
    rr0 = 1'b0; rr1 = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) rr0 = ~rr0;
      if ($urandom_range(0, 29) == 0) rr1 = ~rr1;
      applyStimulus(rr0, rr1, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 8, 24'($urandom), 24'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
